priority_encoder_4x2_seq: RTL

//  Registered 4-to-2 request encoder: the inverse of our 2x4 decoder. Captures
//  4 request lines into a pending register and emits one 2-bit index per

---
 rtl/priority_encoder_4x2_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/priority_encoder_4x2_seq.sv
// Registered 4-to-2 request encoder with pending register and valid/ready out.
// Ports: clk, rst (sync, high), E/D request capture, RDY in; A/V index out,
//        PEND pending status, OVF one-cycle re-request-while-pending pulse.
module priority_encoder_4x2_seq #(
   parameter bit RR = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       E,
   input  logic [3:0] D,
   input  logic       RDY,
   output logic [1:0] A,
   output logic       V,
   output logic [3:0] PEND,
   output logic       OVF
);

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [1:0] a_nx;
   logic [1:0] ptr;
   logic [1:0] ptr_nx;
   logic [3:0] pend_nx;
   logic       ovf_nx;
   logic       xfer;
   logic [3:0] clr;
   logic [3:0] req;
   logic [3:0] s;
   logic [1:0] sel;
   logic [1:0] idx;
   logic       found;

   assign V = (state == VALID);

   always_comb begin
      xfer    = V & RDY;
      clr     = xfer ? (4'b0001 << A) : 4'b0000;
      req     = E ? D : 4'b0000;
      // Arbitrate only over registered pending bits minus the one leaving.
      s       = PEND & ~clr;
      pend_nx = s | req;
      ovf_nx  = |(req & s);

      sel   = 2'd0;
      idx   = 2'd0;
      found = 1'b0;
      if (!RR) begin
         // Ascending scan: the last hit is the highest index.
         for (int i = 0; i < 4; i++) begin
            if (s[i]) sel = 2'(i);
         end
      end else begin
         // Start just after the last served index; j=4 wraps to ptr itself.
         for (int j = 1; j <= 4; j++) begin
            idx = ptr + 2'(j);
            if (!found && s[idx]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end

      state_nx = state;
      a_nx     = A;
      ptr_nx   = ptr;
      unique case (state)
         IDLE: begin
            if (|s) begin
               a_nx     = sel;
               state_nx = VALID;
            end
         end
         VALID: begin
            if (xfer) begin
               if (|s) a_nx = sel;
               else state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (RR && xfer) ptr_nx = A;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         A     <= 2'b00;
         PEND  <= 4'b0000;
         OVF   <= 1'b0;
         ptr   <= 2'd3;
      end else begin
         state <= state_nx;
         A     <= a_nx;
         PEND  <= pend_nx;
         OVF   <= ovf_nx;
         ptr   <= ptr_nx;
      end
   end

endmodule
